// File: rtl/psum_normalizer.sv
// Normalizes a row of partial sums so each lane becomes its share of the total magnitude, scaled by 2^frac.
// Optional build macro NORM_ROUND_EN adds half the divisor to each dividend, so quotients round half-up instead of truncating.
module psum_normalizer #(
  parameter int col = 8,
  parameter int bw_psum = 12,
  parameter int frac = 12,
  localparam int sw = bw_psum + $clog2(col),
  localparam int ow = frac + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sign_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [col*bw_psum-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [col*ow-1:0]     out_data,
  output logic [sw-1:0]         sum_out,
  output logic                  div_zero
);

`ifdef NORM_ROUND_EN
  localparam int dw = bw_psum + frac + 1;
`else
  localparam int dw = bw_psum + frac;
`endif
  localparam int iw = $clog2(col + 1);
  localparam int cw = $clog2(dw + 1);

  typedef enum logic [1:0] {IDLE, SUM, DIV, OUT} state_t;

  state_t state, state_next;

  logic [col*bw_psum-1:0] row;
  logic [col*bw_psum-1:0] row_rot;
  logic                   sign_q;
  logic [sw-1:0]          acc;
  logic [iw-1:0]          lane_idx;
  logic [cw-1:0]          bit_cnt;
  logic [dw-1:0]          dvd;
  logic [sw-1:0]          rem;
  logic [ow-2:0]          quo;
  logic                   neg_q;

  logic [bw_psum-1:0]     lane_raw;
  logic [bw_psum-1:0]     lane_mag;
  logic                   lane_neg;
  logic [dw-1:0]          dividend;
  logic [sw:0]            trial;
  logic [sw-1:0]          diff;
  logic                   ge;
  logic [sw-1:0]          rem_next;
  logic [ow-1:0]          quo_next;
  logic [ow-1:0]          result;
  logic                   lane_last_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // The captured row rotates so the lane being worked on always sits in the low bits.
  assign row_rot = {row[bw_psum-1:0], row[col*bw_psum-1:bw_psum]};

  always_comb begin
    lane_raw = row[bw_psum-1:0];
    lane_neg = sign_q & lane_raw[bw_psum-1];
    lane_mag = lane_neg ? -lane_raw : lane_raw;
`ifdef NORM_ROUND_EN
    dividend = dw'({lane_mag, {frac{1'b0}}}) + dw'(acc >> 1);
`else
    dividend = dw'({lane_mag, {frac{1'b0}}});
`endif
    trial    = {rem, dvd[dw-1]};
    diff     = trial[sw-1:0] - acc;
    ge       = (trial >= {1'b0, acc});
    rem_next = ge ? diff : trial[sw-1:0];
    quo_next = {quo, ge};
    // A zero divisor makes the divider produce all ones, so force the lane to zero.
    result   = (acc == '0) ? '0 : (neg_q ? -quo_next : quo_next);
    lane_last_bit = (bit_cnt == cw'(dw - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = SUM;
      SUM:  if (lane_idx == iw'(col)) state_next = DIV;
      DIV:  if (lane_last_bit && lane_idx == iw'(col - 1)) state_next = OUT;
      OUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row      <= '0;
      sign_q   <= 1'b0;
      acc      <= '0;
      lane_idx <= '0;
      bit_cnt  <= '0;
      dvd      <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      out_data <= '0;
      sum_out  <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            row      <= in_data;
            sign_q   <= sign_mode;
            acc      <= '0;
            lane_idx <= '0;
          end
        end
        SUM: begin
          row <= row_rot;
          // The extra cycle after the last lane loads lane 0 into the divider using the finished sum.
          if (lane_idx == iw'(col)) begin
            dvd      <= dividend;
            rem      <= '0;
            quo      <= '0;
            bit_cnt  <= '0;
            neg_q    <= lane_neg;
            lane_idx <= '0;
          end else begin
            acc      <= acc + sw'(lane_mag);
            lane_idx <= lane_idx + iw'(1);
          end
        end
        DIV: begin
          rem     <= rem_next;
          quo     <= quo_next[ow-2:0];
          dvd     <= dvd << 1;
          bit_cnt <= bit_cnt + cw'(1);
          if (lane_last_bit) begin
            for (int i = 0; i < col; i++) begin
              if (int'(lane_idx) == i) out_data[i*ow +: ow] <= result;
            end
            if (lane_idx == iw'(col - 1)) begin
              sum_out  <= acc;
              div_zero <= (acc == '0);
            end else begin
              dvd      <= dividend;
              rem      <= '0;
              quo      <= '0;
              bit_cnt  <= '0;
              neg_q    <= lane_neg;
              row      <= row_rot;
              lane_idx <= lane_idx + iw'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
